// File: rtl/shared_mem_port_arbiter.sv
// Round-robin arbiter that shares one single-outstanding memory request port
// between NUM_REQ requesters. A grant is held for the whole transaction, from
// request acceptance to response delivery. Priority rotates only on completion.
module shared_mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_resp_valid,
    input  logic [DATA_W-1:0]         mem_resp_rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      protocol_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                perr_q, perr_d;

    logic [ID_W-1:0]     win_hi, win_lo, win;
    logic                hit_hi, hit_lo, any_req;

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_lo = ID_W'(i);
                hit_lo = 1'b1;
                if (ID_W'(i) >= rr_ptr_q) begin
                    win_hi = ID_W'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        any_req = hit_lo;
        win     = hit_hi ? win_hi : win_lo;
    end

    // Next-state and strobe generation for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        req_ready     = '0;
        resp_valid    = '0;
        mem_req_valid = 1'b0;
        // A memory response is only legal while a request is outstanding.
        perr_d        = perr_q | (mem_resp_valid && (state_q != WAIT));

        case (state_q)
            IDLE: begin
                // Strobe is suppressed while reset is held so no requester
                // believes it was accepted by a cycle that is being discarded.
                if (any_req && reset) begin
                    req_ready = NUM_REQ'(1) << win;
                    grant_d   = win;
                    we_d      = req_we[win];
                    addr_d    = req_addr[win*ADDR_W +: ADDR_W];
                    wdata_d   = req_wdata[win*DATA_W +: DATA_W];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = mem_resp_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = NUM_REQ'(1) << grant_q;
                rr_ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            perr_q   <= perr_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign resp_rdata   = rdata_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_shared_mem_port_arbiter.sv
// Testbench for shared_mem_port_arbiter: transaction-level reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_shared_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic            mem_req_ready = 1'b0;
    logic            mem_resp_valid = 1'b0;
    logic [DW-1:0]   mem_resp_rdata = '0;

    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            mem_req_valid;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            protocol_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mem_auto = 1'b0;
    bit rand_req = 1'b0;

    // Reference model: who owns the port, whether the request has been taken
    // by memory, whether the response has arrived, and the round-robin pointer.
    int            m_owner  = -1;
    int            m_ptr    = 0;
    int            m_acc    = -1;
    int            m_gid    = 0;
    bit            m_issued = 1'b0;
    bit            m_resp   = 1'b0;
    bit            m_perr   = 1'b0;
    bit            m_we     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [DW-1:0] m_rdata  = '0;

    int act_log[$];
    int resp_cnt[N];
    int total_resp = 0;

    int           cur_pick;
    logic [N-1:0] e_rr, e_rv;

    always #5 clock = ~clock;

    shared_mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .grant_id(grant_id), .busy(busy), .protocol_err(protocol_err)
    );

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    assign cur_pick = pick(req_valid, m_ptr);
    assign e_rr = (reset && m_owner < 0 && cur_pick >= 0) ? (N'(1) << cur_pick) : '0;
    assign e_rv = (m_owner >= 0 && m_resp) ? (N'(1) << m_owner) : '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model update at each rising edge from the inputs held during the cycle.
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        m_acc <= -1;
        if (!reset) begin
            m_owner  <= -1;
            m_ptr    <= 0;
            m_gid    <= 0;
            m_issued <= 1'b0;
            m_resp   <= 1'b0;
            m_perr   <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rdata  <= '0;
        end else begin
            if (mem_resp_valid && !(m_owner >= 0 && m_issued && !m_resp)) m_perr <= 1'b1;
            if (m_owner < 0) begin
                if (cur_pick >= 0) begin
                    m_owner  <= cur_pick;
                    m_acc    <= cur_pick;
                    m_gid    <= cur_pick;
                    m_issued <= 1'b0;
                    m_resp   <= 1'b0;
                    m_we     <= req_we[cur_pick];
                    m_addr   <= req_addr[cur_pick*AW +: AW];
                    m_wdata  <= req_wdata[cur_pick*DW +: DW];
                end
            end else if (!m_issued) begin
                if (mem_req_ready) m_issued <= 1'b1;
            end else if (!m_resp) begin
                if (mem_resp_valid) begin
                    m_resp  <= 1'b1;
                    m_rdata <= mem_resp_rdata;
                end
            end else begin
                m_ptr   <= (m_owner + 1) % N;
                m_owner <= -1;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clock) begin
        if (cyc > 0) begin
            chk("req_ready", 64'(req_ready), 64'(e_rr));
            chk("resp_valid", 64'(resp_valid), 64'(e_rv));
            chk("busy", 64'(busy), 64'(m_owner >= 0));
            chk("mem_req_valid", 64'(mem_req_valid), 64'(m_owner >= 0 && !m_issued));
            chk("grant_id", 64'(grant_id), 64'(m_gid));
            chk("mem_we", 64'(mem_we), 64'(m_we));
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("protocol_err", 64'(protocol_err), 64'(m_perr));
            chk("req_resp_exclusive", 64'(mem_req_valid && (|resp_valid)), 64'd0);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) act_log.push_back(i);
                if (resp_valid[i]) begin
                    resp_cnt[i] <= resp_cnt[i] + 1;
                    total_resp  <= total_resp + 1;
                end
            end
        end
    end

    task automatic tick(input bit drop = 1'b1);
        @(posedge clock);
        #1;
        if (drop && m_acc >= 0) req_valid[m_acc] = 1'b0;
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_we[i]              = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW]   = $urandom;
                    req_wdata[i*DW +: DW]  = {$urandom, $urandom};
                    req_valid[i]           = 1'b1;
                end
            end
        end
        if (mem_auto) begin
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = (m_owner >= 0 && m_issued && !m_resp) ? ($urandom_range(0, 2) == 0) : 1'b0;
            mem_resp_rdata = {$urandom, $urandom};
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy && c < 400) begin
            tick();
            c++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic mem_quiet();
        mem_auto       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        int c;

        // Reset and idle
        do_reset(3);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("t1_busy", 64'(busy), 64'd0);
            chk("t1_strobes", 64'({req_ready, resp_valid, mem_req_valid}), 64'd0);
        end
        chk("t1_grant_id", 64'(grant_id), 64'd0);
        chk("t1_mem_addr", 64'(mem_addr), 64'd0);
        chk("t1_perr", 64'(protocol_err), 64'd0);

        // Single read with exact latency
        tick();
        req_addr[0 +: AW] = 32'h100;
        req_we[0]         = 1'b0;
        req_valid         = 4'b0001;
        #1;
        chk("t2_c0_req_ready", 64'(req_ready), 64'h1);
        tick();
        mem_req_ready = 1'b1;
        #1;
        chk("t2_c1_mem_req_valid", 64'(mem_req_valid), 64'd1);
        chk("t2_c1_mem_addr", 64'(mem_addr), 64'h100);
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("t2_c2_mem_req_valid", 64'(mem_req_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hDEAD;
        #1;
        chk("t2_c3_resp_valid", 64'(resp_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("t2_c4_resp_valid", 64'(resp_valid), 64'h1);
        chk("t2_c4_resp_rdata", resp_rdata, 64'hDEAD);
        tick();
        #1;
        chk("t2_c5_busy", 64'(busy), 64'd0);

        // All four requesting continuously
        do_reset(2);
        act_log.delete();
        for (int i = 0; i < N; i++) begin
            resp_cnt[i] = 0;
            req_addr[i*AW +: AW] = 32'h1000 + 32'(i);
        end
        req_valid = 4'hF;
        mem_auto  = 1'b1;
        c = 0;
        while (act_log.size() < 5 && c < 400) begin tick(1'b0); c++; end
        for (int i = 0; i < N; i++) chk($sformatf("t3_resp_cnt%0d", i), 64'(resp_cnt[i]), 64'd1);
        c = 0;
        while (act_log.size() < 6 && c < 400) begin tick(1'b0); c++; end
        chk("t3_grant_count", 64'(act_log.size()), 64'd6);
        if (act_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), 64'(act_log[i]), 64'(exp_order[i]));
        end
        req_valid = '0;
        wait_idle("t3_idle");

        // Pointer wrap: serve 2 alone, then 0 and 2 together
        do_reset(2);
        req_valid = 4'b0100;
        tick();
        wait_idle("t4_setup_idle");
        act_log.delete();
        req_valid = 4'b0101;
        c = 0;
        while (act_log.size() < 2 && c < 400) begin tick(); c++; end
        chk("t4_grant_count", 64'(act_log.size()), 64'd2);
        if (act_log.size() >= 2) begin
            chk("t4_first", 64'(act_log[0]), 64'd0);
            chk("t4_second", 64'(act_log[1]), 64'd2);
        end
        wait_idle("t4_idle");

        // Memory stall on a write
        mem_quiet();
        tick();
        req_we[1]            = 1'b1;
        req_addr[1*AW +: AW] = 32'hABC;
        req_wdata[1*DW +: DW] = 64'h1234_5678;
        req_valid            = 4'b0010;
        #1;
        chk("t5_req_ready", 64'(req_ready), 64'h2);
        tick();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t5_stall_valid", 64'(mem_req_valid), 64'd1);
            chk("t5_stall_addr", 64'(mem_addr), 64'hABC);
            chk("t5_stall_we", 64'(mem_we), 64'd1);
            chk("t5_stall_wdata", mem_wdata, 64'h1234_5678);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h77;
        #1;
        chk("t5_wait_valid", 64'(mem_req_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("t5_write_resp", 64'(resp_valid), 64'h2);
        tick();

        // Reset mid-WAIT, stale response, sticky error
        req_valid = 4'b0001;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("t6_busy_wait", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("t6_reset_busy", 64'(busy), 64'd0);
        chk("t6_reset_resp", 64'(resp_valid), 64'd0);
        req_valid = '0;
        tick();
        #1;
        chk("t6_no_late_resp", 64'(resp_valid), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("t6_perr_set", 64'(protocol_err), 64'd1);
        chk("t6_stale_ignored", 64'(resp_valid), 64'd0);
        req_valid = 4'b1000;
        mem_auto  = 1'b1;
        tick();
        wait_idle("t6_txn_idle");
        chk("t6_perr_sticky", 64'(protocol_err), 64'd1);
        mem_quiet();
        do_reset(2);
        #1;
        chk("t6_perr_cleared", 64'(protocol_err), 64'd0);

        // Randomized traffic
        total_resp = 0;
        rand_req   = 1'b1;
        mem_auto   = 1'b1;
        repeat (3000) tick();
        rand_req = 1'b0;
        c = 0;
        while ((req_valid != '0 || busy) && c < 600) begin tick(); c++; end
        chk("t7_drained", 64'({req_valid, busy}), 64'd0);
        chk("t7_activity", 64'(total_resp > 50), 64'd1);
        mem_quiet();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
